// File: rtl/exp_term_accum.sv
// Sums each group of TERMS consecutive EXP series terms and queues the finished sums
// in a small FIFO, which a consumer drains with ready/valid handshaking.
module exp_term_accum #(
    parameter int TERM_W     = 10,
    parameter int TERMS      = 10,
    parameter int GROUPS     = 4,
    parameter int SUM_W      = 14,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [TERM_W-1:0] term_in,
    input  logic              term_valid,
    output logic [SUM_W-1:0]  sum_out,
    output logic [1:0]        sum_grp,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic              done,
    output logic              drop_err,
    output logic              extra_err
);

    localparam int KW = (TERMS > 1) ? $clog2(TERMS) : 1;
    localparam int GW = $clog2(GROUPS + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [SUM_W-1:0] acc_q, acc_d;
    logic [KW-1:0]    k_q, k_d;
    logic [GW-1:0]    g_q, g_d;
    logic [SUM_W-1:0] mem_sum_q [FIFO_DEPTH];
    logic [1:0]       mem_grp_q [FIFO_DEPTH];
    logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d, drop_q, drop_d, extra_q, extra_d;
    logic             push, pop, full, write;
    logic [SUM_W-1:0] sum_next;

    assign sum_valid = (cnt_q != '0);
    assign sum_out   = mem_sum_q[rd_q];
    assign sum_grp   = mem_grp_q[rd_q];
    assign done      = done_q;
    assign drop_err  = drop_q;
    assign extra_err = extra_q;

    assign sum_next = acc_q + SUM_W'(term_in);
    assign pop      = sum_valid & sum_ready;
    assign full     = (cnt_q == CW'(FIFO_DEPTH));

    always_comb begin
        acc_d   = acc_q;
        k_d     = k_q;
        g_d     = g_q;
        push    = 1'b0;
        extra_d = extra_q;
        drop_d  = drop_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        if (term_valid) begin
            if (g_q < GW'(GROUPS)) begin
                if (k_q == KW'(TERMS - 1)) begin
                    push  = 1'b1;
                    acc_d = '0;
                    k_d   = '0;
                    g_d   = g_q + GW'(1);
                end else begin
                    acc_d = sum_next;
                    k_d   = k_q + KW'(1);
                end
            end else begin
                extra_d = 1'b1;
            end
        end
        // A pop on the same edge frees the slot, so a full FIFO can still take the push.
        write = push & (~full | pop);
        if (push & full & ~pop) begin
            drop_d = 1'b1;
        end
        if (write) begin
            wr_d = (wr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_q + PW'(1);
        end
        if (pop) begin
            rd_d = (rd_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_q + PW'(1);
        end
        cnt_d  = cnt_q + CW'(write) - CW'(pop);
        done_d = done_q | ((g_q == GW'(GROUPS)) && (cnt_d == '0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            k_q     <= '0;
            g_q     <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
            extra_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_sum_q[i] <= '0;
                mem_grp_q[i] <= '0;
            end
        end else begin
            acc_q   <= acc_d;
            k_q     <= k_d;
            g_q     <= g_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
            extra_q <= extra_d;
            if (write) begin
                mem_sum_q[wr_q] <= sum_next;
                mem_grp_q[wr_q] <= g_q[1:0];
            end
        end
    end

endmodule

// File: tb/tb_exp_term_accum.sv
// Bench for exp_term_accum: directed group tables, corner sequences, and random traffic
// checked against a queue-based reference model.
module tb_exp_term_accum;

    localparam int TERMS  = 10;
    localparam int GROUPS = 4;
    localparam int DEPTH  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  term_in = '0;
    logic        term_valid = 1'b0;
    logic        sum_ready = 1'b0;
    logic [13:0] sum_out;
    logic [1:0]  sum_grp;
    logic        sum_valid, done, drop_err, extra_err;

    exp_term_accum dut (
        .clk(clk), .reset(reset), .term_in(term_in), .term_valid(term_valid),
        .sum_out(sum_out), .sum_grp(sum_grp), .sum_valid(sum_valid), .sum_ready(sum_ready),
        .done(done), .drop_err(drop_err), .extra_err(extra_err)
    );

    always #5 clk = ~clk;

    typedef struct { int sum; int grp; } ent_t;
    typedef struct { int val; int exp_sum; bit gaps; } vec_t;

    ent_t q[$];
    int   m_acc, m_k, m_g;
    bit   m_drop, m_extra, m_done;
    int   total = 0;
    int   bad = 0;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_k = 0; m_g = 0;
        m_drop = 0; m_extra = 0; m_done = 0;
        q.delete();
    endtask

    task automatic check_model();
        chk("valid", 32'(sum_valid), 32'(q.size() > 0));
        chk("done", 32'(done), 32'(m_done));
        chk("drop_err", 32'(drop_err), 32'(m_drop));
        chk("extra_err", 32'(extra_err), 32'(m_extra));
        if (q.size() > 0) begin
            chk("sum_out", 32'(sum_out), q[0].sum);
            chk("sum_grp", 32'(sum_grp), q[0].grp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic cyc(input bit tv, input int ti, input bit rdy);
        int   sz, g_before;
        bit   pop, push;
        ent_t e;
        term_valid = tv;
        term_in    = ti[9:0];
        sum_ready  = rdy;
        @(posedge clk);
        #1;
        sz       = q.size();
        g_before = m_g;
        pop      = (sz > 0) && rdy;
        push     = 0;
        if (tv) begin
            if (m_g < GROUPS) begin
                m_acc += ti % 1024;
                m_k++;
                if (m_k == TERMS) begin
                    push  = 1;
                    e.sum = m_acc;
                    e.grp = m_g;
                    m_acc = 0;
                    m_k   = 0;
                    m_g++;
                end
            end else begin
                m_extra = 1;
            end
        end
        if (pop) void'(q.pop_front());
        if (push) begin
            if (sz == DEPTH && !pop) m_drop = 1;
            else q.push_back(e);
        end
        if (g_before == GROUPS && q.size() == 0) m_done = 1;
        check_model();
    endtask

    task automatic do_reset();
        term_valid = 0;
        sum_ready  = 0;
        #3;
        reset = 1;
        #1;
        chk("rst_sum_out", 32'(sum_out), 0);
        chk("rst_sum_grp", 32'(sum_grp), 0);
        chk("rst_valid", 32'(sum_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_drop", 32'(drop_err), 0);
        chk("rst_extra", 32'(extra_err), 0);
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
    endtask

    task automatic group(input int val, input bit rdy);
        for (int j = 0; j < TERMS; j++) cyc(1, val, rdy);
    endtask

    initial begin
        tbl[0] = '{1, 10, 0};
        tbl[1] = '{1023, 10230, 0};
        tbl[2] = '{2, 20, 1};
        tbl[3] = '{0, 0, 0};
        tbl[4] = '{100, 1000, 1};
        tbl[5] = '{517, 5170, 1};

        model_reset();
        #1;
        @(posedge clk);
        #1;
        do_reset();

        // Ten ones per group, consumer always ready.
        for (int gi = 0; gi < GROUPS; gi++) begin
            cyc(1, 1, 1);
            if (gi > 0) chk("tp1_one_cycle_valid", 32'(sum_valid), 0);
            for (int j = 1; j < TERMS; j++) cyc(1, 1, 1);
            chk("tp1_valid", 32'(sum_valid), 1);
            chk("tp1_sum", 32'(sum_out), 10);
            chk("tp1_grp", 32'(sum_grp), gi);
            chk("tp1_done_early", 32'(done), 0);
        end
        cyc(0, 0, 1);
        chk("tp1_last_popped", 32'(sum_valid), 0);
        chk("tp1_done", 32'(done), 1);
        chk("tp1_no_drop", 32'(drop_err), 0);
        chk("tp1_no_extra", 32'(extra_err), 0);
        cyc(1, 5, 1);
        chk("extra_err_set", 32'(extra_err), 1);
        chk("extra_no_sum", 32'(sum_valid), 0);
        chk("extra_done_holds", 32'(done), 1);
        cyc(0, 0, 1);
        chk("extra_sticky", 32'(extra_err), 1);

        // Single-group table, with idle gaps between terms on some entries.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            for (int j = 0; j < TERMS; j++) begin
                if (tbl[i].gaps && (j % 3 == 0)) begin
                    cyc(0, $urandom_range(0, 1023), 0);
                    cyc(0, $urandom_range(0, 1023), 0);
                end
                cyc(1, tbl[i].val, 0);
            end
            chk("tbl_valid", 32'(sum_valid), 1);
            chk("tbl_sum", 32'(sum_out), tbl[i].exp_sum);
            chk("tbl_grp", 32'(sum_grp), 0);
        end

        // Stalled consumer across three groups: third sum is lost.
        do_reset();
        group(1, 0);
        group(2, 0);
        chk("stall_no_drop_yet", 32'(drop_err), 0);
        group(3, 0);
        chk("stall_drop", 32'(drop_err), 1);
        for (int j = 0; j < 3; j++) begin
            cyc(0, 0, 0);
            chk("stall_hold_sum", 32'(sum_out), 10);
            chk("stall_hold_grp", 32'(sum_grp), 0);
        end
        cyc(0, 0, 1);
        chk("drain_sum1", 32'(sum_out), 20);
        chk("drain_grp1", 32'(sum_grp), 1);
        cyc(0, 0, 1);
        chk("drain_empty", 32'(sum_valid), 0);
        chk("drain_not_done", 32'(done), 0);

        // Full FIFO, pop on the edge the next sum completes.
        do_reset();
        group(1, 0);
        group(2, 0);
        for (int j = 0; j < TERMS - 1; j++) cyc(1, 3, 0);
        cyc(1, 3, 1);
        chk("fullpop_no_drop", 32'(drop_err), 0);
        chk("fullpop_head_sum", 32'(sum_out), 20);
        chk("fullpop_head_grp", 32'(sum_grp), 1);
        cyc(0, 0, 1);
        chk("fullpop_next_sum", 32'(sum_out), 30);
        chk("fullpop_next_grp", 32'(sum_grp), 2);
        cyc(0, 0, 1);
        chk("fullpop_empty", 32'(sum_valid), 0);

        // Reset in the middle of group 1.
        do_reset();
        group(1, 1);
        for (int j = 0; j < 5; j++) cyc(1, 1, 0);
        do_reset();
        group(2, 0);
        chk("post_rst_sum", 32'(sum_out), 20);
        chk("post_rst_grp", 32'(sum_grp), 0);

        // Random traffic against the reference model.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int c = 0; c < 400; c++) begin
                bit tv, rdy;
                int ti;
                tv  = ($urandom_range(0, 3) != 0);
                ti  = ($urandom_range(0, 4) == 0) ? 1023 : int'($urandom_range(0, 1023));
                rdy = ($urandom_range(0, 3) <= (r % 4));
                cyc(tv, ti, rdy);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
